multi_channel_clock_divider: RTL and testbench

Parametrised successor to the single-channel 100 MHz-to-1 Hz divider. Generates CHANNELS independent square-wave clock enables from Clock_100MHz, each with a half-period programmable at run time, per-channel enable, glitch-free divisor update and a global phase-align pulse. Sits between the board oscillator and slow consumers (display refresh, debouncers, seconds counters) that need several derived rates from one block.

---
 rtl/multi_channel_clock_divider.sv | 109 ++++++++++
 tb/tb_multi_channel_clock_divider.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multi_channel_clock_divider.sv
// multi_channel_clock_divider
//   CHANNELS independent square-wave clock enables derived from Clock_100MHz.
//   Each channel has a run-time programmable half-period. New values go to a
//   shadow register and only become active at the channel's next wrap, or at
//   Sync. A global Sync restarts every channel in phase.
//
// Ports
//   Clock_100MHz      in   sole clock, rising edge
//   Clear_n           in   async active-low reset
//   Enable[CH]        in   per-channel run enable
//   Load              in   strobe: shadow[Load_Channel] <= Load_Half_Period
//   Load_Channel[SEL] in   target channel (>= CHANNELS is ignored)
//   Load_Half_Period  in   new half-period in cycles (0 behaves as 1)
//   Sync              in   strobe: restart all channels at phase 0
//   Clock_Out[CH]     out  registered square wave
//   Tick[CH]          out  registered pulse in the cycle Clock_Out rises

module mccd_lane #(
  parameter int WIDTH        = 26,
  parameter int DEFAULT_HALF = 50000000
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             clk_out,
  output logic             tick
);
  logic [WIDTH-1:0] s_q, h_q, c_q;
  logic [WIDTH-1:0] term, s_new;

  // H==0 and H==1 share terminal 0, so a zero load toggles every cycle.
  always_comb begin
    term  = (h_q == '0) ? '0 : h_q - 1'b1;
    // Write-through view of the shadow, used only when Sync takes it this cycle.
    s_new = load ? load_val : s_q;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      s_q     <= WIDTH'(DEFAULT_HALF);
      h_q     <= WIDTH'(DEFAULT_HALF);
      c_q     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      s_q <= s_new;
      if (sync) begin
        c_q     <= '0;
        clk_out <= 1'b0;
        h_q     <= s_new;
        tick    <= 1'b0;
      end else if (en) begin
        if (c_q == term) begin
          c_q     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
          // Old shadow only: a load in this same cycle waits for the next wrap.
          h_q     <= s_q;
        end else begin
          c_q  <= c_q + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end
endmodule

module multi_channel_clock_divider #(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 26,
  parameter int DEFAULT_HALF = 50000000,
  parameter int SEL_W        = 1
) (
  input  logic                Clock_100MHz,
  input  logic                Clear_n,
  input  logic [CHANNELS-1:0] Enable,
  input  logic                Load,
  input  logic [SEL_W-1:0]    Load_Channel,
  input  logic [WIDTH-1:0]    Load_Half_Period,
  input  logic                Sync,
  output logic [CHANNELS-1:0] Clock_Out,
  output logic [CHANNELS-1:0] Tick
);
  logic [CHANNELS-1:0] load_hit;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    // Out-of-range channel numbers match no lane, so the write is dropped.
    assign load_hit[i] = Load && (Load_Channel == SEL_W'(i));

    mccd_lane #(
      .WIDTH        (WIDTH),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_lane (
      .gclk     (Clock_100MHz),
      .grst_n   (Clear_n),
      .en       (Enable[i]),
      .sync     (Sync),
      .load     (load_hit[i]),
      .load_val (Load_Half_Period),
      .clk_out  (Clock_Out[i]),
      .tick     (Tick[i])
    );
  end
endmodule

// File: tb/tb_multi_channel_clock_divider.sv
module tb_multi_channel_clock_divider;
  localparam int CH = 2, W = 8, DH = 5, SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '0;
  logic          load = 1'b0;
  logic [SW-1:0] lch = '0;
  logic [W-1:0]  lval = '0;
  logic          sync = 1'b0;
  logic [CH-1:0] co, tk;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_channel_clock_divider #(
    .CHANNELS(CH), .WIDTH(W), .DEFAULT_HALF(DH), .SEL_W(SW)
  ) dut (
    .Clock_100MHz     (clk),
    .Clear_n          (rst_n),
    .Enable           (en),
    .Load             (load),
    .Load_Channel     (lch),
    .Load_Half_Period (lval),
    .Sync             (sync),
    .Clock_Out        (co),
    .Tick             (tk)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per channel, enabled edges elapsed in the current half,
  // output level, active and shadow half-periods.
  int            m_hp[CH], m_sh[CH], m_done[CH];
  logic [CH-1:0] m_lvl, m_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        m_hp[i]   <= DH;
        m_sh[i]   <= DH;
        m_done[i] <= 0;
      end
      m_lvl  <= '0;
      m_tick <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (sync) begin
          m_done[i] <= 0;
          m_lvl[i]  <= 1'b0;
          m_tick[i] <= 1'b0;
          m_hp[i]   <= (load && int'(lch) == i) ? int'(lval) : m_sh[i];
        end else if (en[i] && (m_done[i] + 1 >= ((m_hp[i] < 1) ? 1 : m_hp[i]))) begin
          m_done[i] <= 0;
          m_lvl[i]  <= ~m_lvl[i];
          m_tick[i] <= ~m_lvl[i];
          m_hp[i]   <= m_sh[i];
        end else if (en[i]) begin
          m_done[i] <= m_done[i] + 1;
          m_tick[i] <= 1'b0;
        end else begin
          m_tick[i] <= 1'b0;
        end
        if (load && int'(lch) == i) m_sh[i] <= int'(lval);
      end
    end
  end

  // Cycle-by-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_clock_out", int'(co), int'(m_lvl));
    check("model_tick", int'(tk), int'(m_tick));
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    edges(2);
    check("reset_clock_out", int'(co), 0);
    check("reset_tick", int'(tk), 0);

    // Release reset; edge n below is the n-th rising edge after release.
    en    = 2'b11;
    rst_n = 1'b1;
    edges(1);
    load = 1'b1; lch = 2'd1; lval = 8'd3;  // sampled at edge 2
    edges(1);
    load = 1'b0;
    edges(3);                               // edge 5
    check("first_rise", int'(co), 3);
    check("first_tick", int'(tk), 3);
    edges(3);                               // edge 8: ch1 now on H=3
    check("ch1_fall8", int'(co), 1);
    check("tick8", int'(tk), 0);
    edges(2);                               // edge 10
    check("ch0_fall10", int'(co), 0);
    edges(1);                               // edge 11
    check("ch1_rise11", int'(co), 2);
    check("ch1_tick11", int'(tk), 2);

    // Hold ch0 for edges 12..15; its half that began at 10 ends at 19.
    en = 2'b10;
    edges(4);
    en = 2'b11;
    edges(3);                               // edge 18
    check("hold_ch0_low18", int'(co[0]), 0);
    edges(1);                               // edge 19
    check("hold_ch0_rise19", int'(co[0]), 1);
    check("hold_ch0_tick19", int'(tk[0]), 1);

    // ch0 <- 0, then Sync with an out-of-range load that must be dropped.
    load = 1'b1; lch = 2'd0; lval = 8'd0;
    edges(1);
    load = 1'b1; lch = 2'd3; lval = 8'd9; sync = 1'b1;
    edges(1);
    load = 1'b0; sync = 1'b0;
    check("sync_zero", int'(co), 0);
    edges(1);
    check("fast_ch0_1", int'(co), 1);
    edges(1);
    check("fast_ch0_2", int'(co), 0);
    edges(1);
    check("fast_sync3", int'(co), 3);
    check("fast_tick3", int'(tk), 3);

    // Sync with write-through load of ch1=7.
    edges(1);
    load = 1'b1; lch = 2'd1; lval = 8'd7; sync = 1'b1;
    edges(1);
    load = 1'b0; sync = 1'b0;
    check("sync2_zero", int'(co), 0);
    edges(6);
    check("wt_ch1_low6", int'(co[1]), 0);
    edges(1);
    check("wt_ch1_rise7", int'(co[1]), 1);
    check("wt_ch1_tick7", int'(tk[1]), 1);

    // Randomized traffic, checked by the compare process.
    for (int n = 0; n < 3000; n++) begin
      en   = ($urandom_range(0, 3) != 0) ? 2'b11 : CH'($urandom_range(0, 3));
      load = ($urandom_range(0, 7) == 0);
      lch  = SW'($urandom_range(0, 3));
      lval = W'($urandom_range(0, 12));
      sync = ($urandom_range(0, 39) == 0);
      edges(1);
    end

    // Asynchronous clear mid-cycle; then defaults must be back.
    en = 2'b11; load = 1'b1; lch = 2'd0; lval = 8'd2; sync = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_clock_out", int'(co), 0);
    check("async_tick", int'(tk), 0);
    load = 1'b0;
    edges(2);
    rst_n = 1'b1;
    edges(4);
    check("post_reset_low4", int'(co), 0);
    edges(1);
    check("post_reset_rise5", int'(co), 3);
    edges(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
